// File: rtl/clock_ctrl.sv
// rtl/clock_ctrl.sv - CPU clock generator with free-run, debounced single-step and halt
//
// Ports:
//   clk          system clock, all logic on its rising edge
//   reset_n      asynchronous active-low reset
//   mode_run     asynchronous slide switch: 1 = free run, 0 = manual step
//   step_btn     asynchronous raw pushbutton, active high, bouncy
//   halt         CPU halt request, synchronous to clk, level-sensitive
//   half_period  run-mode phase length in clk cycles (0 is treated as 1)
//   clk_cpu      registered CPU clock
//   running      high while free-running (low or high phase)
//   halted       high once the CPU has halted; cleared only by reset
module clock_ctrl #(
    parameter int DEBOUNCE_CYCLES  = 500000,
    parameter int STEP_HIGH_CYCLES = 5000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mode_run,
    input  logic        step_btn,
    input  logic        halt,
    input  logic [31:0] half_period,
    output logic        clk_cpu,
    output logic        running,
    output logic        halted
);

    localparam logic [31:0] DEB_LAST  = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] STEP_LAST = 32'(STEP_HIGH_CYCLES - 1);

    typedef enum logic [2:0] {
        MANUAL,
        STEP_HI,
        RUN_LO,
        RUN_HI,
        HALTED
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [1:0]  mode_sync;
    logic [1:0]  btn_sync;
    logic        mode_s;
    logic        btn_s;

    logic        deb_level;
    logic        deb_prev;
    logic [31:0] deb_cnt;
    logic        step_strobe;

    logic [31:0] phase_cnt;
    logic [31:0] phase_last;
    logic        phase_done;
    logic        halt_latch;
    logic        halt_pend;
    logic        state_change;

    // Two-flop synchronizers for the asynchronous switch and button
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_sync <= 2'b00;
            btn_sync  <= 2'b00;
        end else begin
            mode_sync <= {mode_sync[0], mode_run};
            btn_sync  <= {btn_sync[0], step_btn};
        end
    end

    assign mode_s = mode_sync[1];
    assign btn_s  = btn_sync[1];

    // Debouncer: the accepted level follows the button only after it has
    // disagreed for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_level <= 1'b0;
            deb_prev  <= 1'b0;
            deb_cnt   <= 32'd0;
        end else begin
            deb_prev <= deb_level;
            if (btn_s != deb_level) begin
                if (deb_cnt == DEB_LAST) begin
                    deb_level <= btn_s;
                    deb_cnt   <= 32'd0;
                end else begin
                    deb_cnt <= deb_cnt + 32'd1;
                end
            end else begin
                deb_cnt <= 32'd0;
            end
        end
    end

    assign step_strobe = deb_level & ~deb_prev;

    // A halt seen during a high phase is honoured when that phase ends
    assign halt_pend    = halt_latch | halt;
    assign phase_done   = (state == STEP_HI) ? (phase_cnt == STEP_LAST)
                                             : (phase_cnt == phase_last);
    assign state_change = (state_next != state);

    always_comb begin
        state_next = state;
        case (state)
            MANUAL: begin
                if (halt)             state_next = HALTED;
                else if (mode_s)      state_next = RUN_LO;
                else if (step_strobe) state_next = STEP_HI;
            end
            STEP_HI: begin
                if (phase_done)       state_next = halt_pend ? HALTED : MANUAL;
            end
            RUN_LO: begin
                if (halt)             state_next = HALTED;
                else if (!mode_s)     state_next = MANUAL;
                else if (phase_done)  state_next = RUN_HI;
            end
            RUN_HI: begin
                if (phase_done) begin
                    if (halt_pend)    state_next = HALTED;
                    else if (!mode_s) state_next = MANUAL;
                    else              state_next = RUN_LO;
                end
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next = MANUAL;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state register and come straight out of flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= MANUAL;
            clk_cpu <= 1'b0;
            running <= 1'b0;
            halted  <= 1'b0;
        end else begin
            state   <= state_next;
            clk_cpu <= (state_next == STEP_HI) || (state_next == RUN_HI);
            running <= (state_next == RUN_LO) || (state_next == RUN_HI);
            halted  <= (state_next == HALTED);
        end
    end

    // Phase counter, per-phase length snapshot and halt latch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_cnt  <= 32'd0;
            phase_last <= 32'd0;
            halt_latch <= 1'b0;
        end else begin
            if (state_change) begin
                phase_cnt <= 32'd0;
            end else if ((state == STEP_HI) || (state == RUN_LO) || (state == RUN_HI)) begin
                phase_cnt <= phase_cnt + 32'd1;
            end

            // half_period is sampled only on phase entry; zero means one cycle
            if (state_change && ((state_next == RUN_LO) || (state_next == RUN_HI))) begin
                phase_last <= (half_period == 32'd0) ? 32'd0 : half_period - 32'd1;
            end

            if (state_change) begin
                halt_latch <= 1'b0;
            end else if (((state == STEP_HI) || (state == RUN_HI)) && halt) begin
                halt_latch <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clock_ctrl.sv
// tb/tb_clock_ctrl.sv - table-driven scoreboard bench for clock_ctrl
module tb_clock_ctrl;

    logic        clk;
    logic        reset_n;
    logic        mode_run;
    logic        step_btn;
    logic        halt;
    logic [31:0] half_period;
    logic        clk_cpu;
    logic        running;
    logic        halted;

    clock_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .STEP_HIGH_CYCLES(3)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mode_run   (mode_run),
        .step_btn   (step_btn),
        .halt       (halt),
        .half_period(half_period),
        .clk_cpu    (clk_cpu),
        .running    (running),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record = n cycles of constant inputs; bit i of pat is the expected
    // clk_cpu in the i-th cycle of the record.
    typedef struct {
        logic        rst;
        logic        mode;
        logic        btn;
        logic        hlt;
        logic [31:0] hp;
        int          n;
        logic [31:0] pat;
        logic        run;
        logic        hlt_o;
    } vec_t;

    typedef struct {
        logic [2:0] exp;
        int         vec;
        int         cyc;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   checks;
    int   failures;

    function automatic void add(input logic rst, input logic mode, input logic btn,
                                input logic hlt, input logic [31:0] hp, input int n,
                                input logic [31:0] pat, input logic run, input logic hlt_o);
        vec_t v;
        v.rst = rst; v.mode = mode; v.btn = btn; v.hlt = hlt; v.hp = hp;
        v.n = n; v.pat = pat; v.run = run; v.hlt_o = hlt_o;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int vec, input int cyc,
                         input logic [2:0] got, input logic [2:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s vec%0d cyc%0d: clk_cpu/running/halted got %b expected %b",
                     name, vec, cyc, got, exp);
        end
    endtask

    initial begin
        sb_t  e;
        int   waited;
        checks   = 0;
        failures = 0;
        reset_n     = 1'b0;
        mode_run    = 1'b0;
        step_btn    = 1'b0;
        halt        = 1'b0;
        half_period = 32'd0;

        // Free run, half_period 2 then changed to 5 inside a high phase
        add(0,1,0,0,2, 3,32'h000,0,0);
        add(1,1,0,0,2, 2,32'h000,0,0);
        add(1,1,0,0,2,10,32'h0CC,1,0);
        add(1,1,0,0,2, 1,32'h001,1,0);
        add(1,1,0,0,5,15,32'h7C1,1,0);
        // half_period 0 behaves as 1
        add(0,1,0,0,0, 2,32'h000,0,0);
        add(1,1,0,0,0, 2,32'h000,0,0);
        add(1,1,0,0,0, 8,32'h0AA,1,0);
        // Manual step: long press, short press, bounce during STEP_HI
        add(0,0,0,0,2, 2,32'h000,0,0);
        add(1,0,0,0,2, 3,32'h000,0,0);
        add(1,0,1,0,2,10,32'h1C0,0,0);
        add(1,0,0,0,2,10,32'h000,0,0);
        add(1,0,1,0,2, 2,32'h000,0,0);
        add(1,0,0,0,2,10,32'h000,0,0);
        add(1,0,1,0,2, 6,32'h000,0,0);
        add(1,0,0,0,2, 1,32'h001,0,0);
        add(1,0,1,0,2,10,32'h003,0,0);
        add(1,0,0,0,2, 8,32'h000,0,0);
        // Halt in MANUAL takes effect next cycle and sticks
        add(0,0,0,0,2, 2,32'h000,0,0);
        add(1,0,0,0,2, 3,32'h000,0,0);
        add(1,0,0,1,2, 1,32'h000,0,1);
        add(1,0,0,0,2, 3,32'h000,0,1);
        // Halt pulse in 2nd cycle of RUN_HI: high completes, then sticky HALTED
        add(0,1,0,0,4, 2,32'h000,0,0);
        add(1,1,0,0,4, 2,32'h000,0,0);
        add(1,1,0,0,4, 5,32'h010,1,0);
        add(1,1,0,1,4, 1,32'h001,1,0);
        add(1,1,0,0,4, 2,32'h003,1,0);
        add(1,1,0,0,4, 4,32'h000,0,1);
        add(1,0,1,0,4,12,32'h000,0,1);
        add(1,1,0,0,4, 6,32'h000,0,1);
        add(0,1,0,0,4, 2,32'h000,0,0);
        // mode_run dropped in 1st cycle of RUN_HI
        add(0,1,0,0,4, 2,32'h000,0,0);
        add(1,1,0,0,4, 2,32'h000,0,0);
        add(1,1,0,0,4, 4,32'h000,1,0);
        add(1,0,0,0,4, 4,32'h00F,1,0);
        add(1,0,0,0,4, 4,32'h000,0,0);

        for (int v = 0; v < vecs.size(); v++) begin
            for (int c = 0; c < vecs[v].n; c++) begin
                @(negedge clk);
                reset_n     = vecs[v].rst;
                mode_run    = vecs[v].mode;
                step_btn    = vecs[v].btn;
                halt        = vecs[v].hlt;
                half_period = vecs[v].hp;
                e.exp = {vecs[v].pat[c], vecs[v].run, vecs[v].hlt_o};
                e.vec = v;
                e.cyc = c;
                sb.push_back(e);
                @(posedge clk);
                #1;
                e = sb.pop_front();
                check("table", e.vec, e.cyc, {clk_cpu, running, halted}, e.exp);
            end
        end

        // Reset in the 2nd cycle of STEP_HI clears clk_cpu without a clock edge
        @(negedge clk);
        reset_n  = 1'b0;
        mode_run = 1'b0;
        step_btn = 1'b0;
        halt     = 1'b0;
        repeat (2) @(negedge clk);
        reset_n  = 1'b1;
        step_btn = 1'b1;
        waited   = 0;
        while (clk_cpu !== 1'b1 && waited < 40) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("step_hi_reached", 0, waited, {clk_cpu, running, halted}, 3'b100);
        @(posedge clk);
        #3;
        check("step_hi_2nd_cycle", 0, 1, {clk_cpu, running, halted}, 3'b100);
        reset_n = 1'b0;
        #1;
        check("async_reset", 0, 2, {clk_cpu, running, halted}, 3'b000);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
